// File: rtl/mask_pixel_feeder.sv
// ============================================================================
// Module   : mask_pixel_feeder
// Function : Frame store for the Mask filter. The host loads one frame, then
//            the block streams it in raster order under busy back-pressure.
//            Option macro FEEDER_CHECKSUM_EN adds a 16-bit pixel checksum port.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mask_pixel_feeder #(
   parameter int N_PIX = 256,
   parameter int AW    = 8,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          start,
   input  logic          busy,
   output logic [DW-1:0] data_out,
   output logic          pix_valid,
   output logic          feeding,
   output logic          idle,
   output logic          done
`ifdef FEEDER_CHECKSUM_EN
   ,output logic [15:0]  checksum
`endif
);

   localparam int          c_IW   = (N_PIX > 1) ? $clog2(N_PIX) : 1;
   localparam logic [AW:0] c_NPIX = (AW+1)'(N_PIX);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FEED = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [c_IW-1:0]   r_rd_ptr;
   logic [DW-1:0]     r_mem [0:N_PIX-1];
   logic              w_wr_ok;
   logic              w_consume;
   logic              w_last;
   logic [DW-1:0]     w_pix;

   assign w_wr_ok = ({1'b0, wr_addr} < c_NPIX);
   assign w_pix   = r_mem[r_rd_ptr];
   assign w_last  = (r_rd_ptr == {c_IW{1'b1}});

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_rd_ptr <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_consume)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         else if (r_state != S_FEED)
            r_rd_ptr <= '0;
      end
   end

   // Frame store is deliberately not reset; it is write-protected outside IDLE.
   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && wr_en && w_wr_ok)
         r_mem[wr_addr[c_IW-1:0]] <= wr_data;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_consume   = 1'b0;
      data_out    = '0;
      pix_valid   = 1'b0;
      feeding     = 1'b0;
      idle        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            idle = 1'b1;
            if (start)
               w_state_nxt = S_FEED;
         end
         S_FEED: begin
            feeding   = 1'b1;
            data_out  = w_pix;
            pix_valid = !busy;
            w_consume = !busy;
            if (!busy && w_last)
               w_state_nxt = S_DONE;
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

`ifdef FEEDER_CHECKSUM_EN
   logic [15:0] r_checksum;

   always_ff @(posedge clk) begin
      if (rst)
         r_checksum <= '0;
      else if (r_state == S_IDLE && start)
         r_checksum <= '0;
      else if (w_consume)
         r_checksum <= r_checksum + 16'(data_out);
   end

   assign checksum = r_checksum;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mask_pixel_feeder.sv
// ============================================================================
// Module   : tb_mask_pixel_feeder
// Function : Directed self-checking bench for mask_pixel_feeder.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mask_pixel_feeder;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       start = 1'b0;
   logic       busy = 1'b0;
   logic [7:0] data_out;
   logic       pix_valid;
   logic       feeding;
   logic       idle;
   logic       done;
`ifdef FEEDER_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0] exp_mem [256];

   always #5 clk = ~clk;

   mask_pixel_feeder #(.N_PIX(256), .AW(8), .DW(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .start     (start),
      .busy      (busy),
      .data_out  (data_out),
      .pix_valid (pix_valid),
      .feeding   (feeding),
      .idle      (idle),
      .done      (done)
`ifdef FEEDER_CHECKSUM_EN
      ,.checksum (checksum)
`endif
   );

   // mode 0: i, mode 1: 255-i, mode 2: 0x01. Optional start on the last write.
   task automatic load_frame(input int mode, input bit start_last);
      for (int i = 0; i < 256; i++) begin
         wr_en   = 1'b1;
         wr_addr = 8'(i);
         wr_data = (mode == 0) ? 8'(i) : (mode == 1) ? 8'(255 - i) : 8'h01;
         exp_mem[i] = wr_data;
         start   = start_last && (i == 255);
         @(posedge clk); #1;
      end
      wr_en = 1'b0;
      start = 1'b0;
   endtask

   // Observes one stream and returns error tallies; the callers judge them.
   task automatic run_stream(input bit issue_start, input int period, input bit abuse,
                             input int stop_after,
                             output int n_cons, output int seq_err, output int stab_err,
                             output int pv_err, output int done_cnt, output int done_cyc);
      logic [7:0] held;
      bit         was_busy;
      n_cons = 0; seq_err = 0; stab_err = 0; pv_err = 0; done_cnt = 0; done_cyc = 0;
      held = '0; was_busy = 1'b0;
      if (issue_start) begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      for (int c = 1; c <= 2000; c++) begin
         busy = (period != 0) && (c % period == 0);
         if (abuse) begin
            wr_en   = (c == 2);
            wr_addr = 8'd5;
            wr_data = 8'hAA;
            start   = (c == 3);
         end
         #1;
         if (feeding) begin
            if (was_busy && data_out !== held) stab_err++;
            if (pix_valid !== !busy) pv_err++;
            if (!busy) begin
               if (n_cons > 255 || data_out !== exp_mem[n_cons]) seq_err++;
               n_cons++;
            end
            held     = data_out;
            was_busy = busy;
         end else begin
            if (pix_valid !== 1'b0) pv_err++;
            was_busy = 1'b0;
         end
         if (done) begin
            done_cnt++;
            done_cyc = c;
         end
         if (stop_after > 0 && n_cons == stop_after) break;
         if (idle && c > 1) break;
         @(posedge clk); #1;
      end
      busy  = 1'b0;
      wr_en = 1'b0;
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (data_out !== 8'h00) $display("FAIL rst_data_out got %h want 00", data_out); else n_pass++;
      n_checks++; if (pix_valid !== 1'b0) $display("FAIL rst_pix_valid got %b want 0", pix_valid); else n_pass++;
      n_checks++; if (feeding !== 1'b0) $display("FAIL rst_feeding got %b want 0", feeding); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else n_pass++;
      n_checks++; if (idle !== 1'b1) $display("FAIL rst_idle got %b want 1", idle); else n_pass++;
      rst = 1'b0;
      start = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (idle !== 1'b1 || feeding !== 1'b0)
         $display("FAIL rst_start_ignored idle=%b feeding=%b want idle=1 feeding=0", idle, feeding);
      else n_pass++;
   endtask

   task automatic test_full_rate();
      int nc, se, st, pv, dc, dy;
      load_frame(0, 1'b0);
      run_stream(1'b1, 0, 1'b0, 0, nc, se, st, pv, dc, dy);
      n_checks++; if (se !== 0) $display("FAIL full_seq errors=%0d want 0", se); else n_pass++;
      n_checks++; if (nc !== 256) $display("FAIL full_count got %0d want 256", nc); else n_pass++;
      n_checks++; if (pv !== 0) $display("FAIL full_pix_valid errors=%0d want 0", pv); else n_pass++;
      n_checks++; if (dc !== 1) $display("FAIL full_done_count got %0d want 1", dc); else n_pass++;
      n_checks++; if (dy !== 257) $display("FAIL full_done_cycle got %0d want 257", dy); else n_pass++;
`ifdef FEEDER_CHECKSUM_EN
      n_checks++; if (checksum !== 16'h7F80) $display("FAIL full_checksum got %h want 7f80", checksum); else n_pass++;
`endif
   endtask

   task automatic test_back_pressure();
      int nc, se, st, pv, dc, dy;
      load_frame(1, 1'b0);
      run_stream(1'b1, 3, 1'b0, 0, nc, se, st, pv, dc, dy);
      n_checks++; if (se !== 0) $display("FAIL bp_seq errors=%0d want 0", se); else n_pass++;
      n_checks++; if (nc !== 256) $display("FAIL bp_count got %0d want 256", nc); else n_pass++;
      n_checks++; if (st !== 0) $display("FAIL bp_stable errors=%0d want 0", st); else n_pass++;
      n_checks++; if (pv !== 0) $display("FAIL bp_pix_valid errors=%0d want 0", pv); else n_pass++;
      n_checks++; if (dc !== 1) $display("FAIL bp_done_count got %0d want 1", dc); else n_pass++;
`ifdef FEEDER_CHECKSUM_EN
      n_checks++; if (checksum !== 16'h7F80) $display("FAIL bp_checksum got %h want 7f80", checksum); else n_pass++;
`endif
   endtask

   task automatic test_write_protect();
      int nc, se, st, pv, dc, dy;
      run_stream(1'b1, 0, 1'b1, 0, nc, se, st, pv, dc, dy);
      n_checks++; if (se !== 0) $display("FAIL wp_seq errors=%0d want 0", se); else n_pass++;
      n_checks++; if (nc !== 256) $display("FAIL wp_count got %0d want 256", nc); else n_pass++;
      n_checks++; if (dc !== 1) $display("FAIL wp_done_count got %0d want 1", dc); else n_pass++;
   endtask

   task automatic test_mid_reset();
      int nc, se, st, pv, dc, dy;
      int bad;
      run_stream(1'b1, 0, 1'b0, 100, nc, se, st, pv, dc, dy);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (idle !== 1'b1 || feeding !== 1'b0)
         $display("FAIL mid_rst_idle idle=%b feeding=%b want idle=1 feeding=0", idle, feeding);
      else n_pass++;
      rst = 1'b0;
      bad = (done !== 1'b0) ? 1 : 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (done !== 1'b0) bad++;
      end
      n_checks++; if (bad !== 0) $display("FAIL mid_rst_no_done done_pulses=%0d want 0", bad); else n_pass++;
      run_stream(1'b1, 0, 1'b0, 0, nc, se, st, pv, dc, dy);
      n_checks++; if (se !== 0) $display("FAIL restart_seq errors=%0d want 0", se); else n_pass++;
      n_checks++; if (nc !== 256) $display("FAIL restart_count got %0d want 256", nc); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int nc, se, st, pv, dc, dy;
      load_frame(2, 1'b1);
      run_stream(1'b0, 0, 1'b0, 0, nc, se, st, pv, dc, dy);
      n_checks++; if (se !== 0) $display("FAIL b2b_seq errors=%0d want 0", se); else n_pass++;
      n_checks++; if (nc !== 256) $display("FAIL b2b_count got %0d want 256", nc); else n_pass++;
      n_checks++; if (dc !== 1) $display("FAIL b2b_done_count got %0d want 1", dc); else n_pass++;
`ifdef FEEDER_CHECKSUM_EN
      n_checks++; if (checksum !== 16'h0100) $display("FAIL b2b_checksum got %h want 0100", checksum); else n_pass++;
`endif
   endtask

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_full_rate();
      test_back_pressure();
      test_write_protect();
      test_mid_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mask_pixel_feeder.md
Name: mask_pixel_feeder

Overview:
- Upstream stage of the Mask filter. Holds one N_PIX-pixel frame (16x16 at 8 bits by default) in a local register file, loaded by a host write port.
- On start, streams the frame in raster order into Mask's data_in and obeys Mask's busy back-pressure.
- Pulses done after the last pixel has been consumed, so the host can reload the frame and restart.

Parameters:
- N_PIX, 256, pixels per frame; must be a power of two, at most 2^AW.
- AW, 8, address width of the frame store and write port.
- DW, 8, pixel width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous active-high reset.
- wr_en  input  1  host write strobe for the frame store.
- wr_addr  input  AW  host write address.
- wr_data  input  DW  host write pixel.
- start  input  1  one-cycle request to begin streaming the frame.
- busy  input  1  back-pressure from Mask; when high, the current pixel is not consumed.
- data_out  output  DW  pixel to Mask data_in.
- pix_valid  output  1  high while data_out carries a pixel that Mask will consume on the next rising edge.
- feeding  output  1  high while in state FEED.
- idle  output  1  high in state IDLE; the frame store is writable.
- done  output  1  one-cycle pulse after the last pixel is consumed.

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE and rd_ptr to 0.
  - data_out=0, pix_valid=0, feeding=0, done=0, idle=1.
  - Frame store contents are not reset.
  - Reset in the middle of FEED aborts the stream immediately; no done pulse is produced.
- States: IDLE, FEED, DONE.
- IDLE:
  - wr_en=1 writes wr_data to mem[wr_addr] at the edge. Addresses >= N_PIX are ignored.
  - start=1 moves to FEED with rd_ptr=0.
  - If wr_en and start are both high in the same cycle, the write is performed and start is also accepted.
  - data_out=0.
- FEED:
  - data_out = mem[rd_ptr], a combinational read of the registered store. It is stable for the whole cycle.
  - pix_valid = !busy.
  - At a rising edge with busy=0, the pixel counts as consumed and rd_ptr increments.
  - If the consumed pixel was rd_ptr = N_PIX-1, the next state is DONE.
  - While busy=1, rd_ptr holds and data_out keeps presenting the same pixel, with no skip or duplicate. Busy may stay high for any number of cycles.
  - wr_en is ignored in FEED and in DONE (frame store is write-protected).
  - start is ignored in FEED and in DONE.
- DONE:
  - done=1 and data_out=0 for exactly one cycle.
  - Unconditional transition to IDLE; rd_ptr returns to 0.
- Timing:
  - First pixel appears on data_out the cycle after start is sampled.
  - With busy held low, the frame takes exactly N_PIX cycles in FEED.
  - done asserts N_PIX+1 cycles after the start edge.
- Ordering: pixels leave strictly in address order 0..N_PIX-1. The rd_ptr wrap is never exercised because the transition to DONE happens first.
- busy is sampled only in FEED; its value in IDLE or DONE has no effect.

Optional Feature:
- Macro: FEEDER_CHECKSUM_EN.
- When defined:
  - Adds output port checksum, width 16: the modulo-2^16 sum of every pixel consumed in the current or most recent frame.
  - Cleared to 0 when start is accepted and on reset.
  - Accumulates data_out at each consuming edge.
  - Holds its value from DONE until the next start.
- When undefined: the port and the adder are absent. All other behaviour and timing are identical.

Test Plan:
- Reset then idle:
  - Stimulus: assert rst for 2 cycles.
  - Required response: data_out=0, pix_valid=0, feeding=0, done=0, idle=1.
  - Also pulse start in the same cycle as rst=1: the block stays in IDLE.
- Full-rate stream:
  - Stimulus: load mem[i]=i, pulse start, busy=0 throughout.
  - Required response: data_out sequence 0x00..0xFF on 256 consecutive cycles; done pulses exactly once, on cycle 257 after start.
  - Checksum (when FEEDER_CHECKSUM_EN is defined): 0x7F80.
- Back-pressure:
  - Stimulus: load mem[i]=255-i, busy high on every third cycle of FEED.
  - Required response: each value 0xFF..0x00 consumed exactly once in order; data_out is stable while busy=1.
- Write protection and ignored start:
  - Stimulus: during FEED write wr_addr=5, wr_data=0xAA and pulse start again.
  - Required response: pixel 5 is still its preloaded value; the stream is not restarted; exactly one done pulse.
- Mid-stream reset:
  - Stimulus: assert rst after 100 pixels.
  - Required response: IDLE next cycle, no done pulse.
  - Then pulse start: stream restarts at pixel 0 and frame contents are intact.
- Back-to-back frames:
  - Stimulus: after done, reload with mem[i]=0x01 and start in the first IDLE cycle.
  - Required response: 256 pixels of 0x01.
  - Checksum (when FEEDER_CHECKSUM_EN is defined): 0x0100.
